dmem_responder: RTL



---
 rtl/dmem_responder_pkg.sv | 26 ++
 rtl/dmem_sram.sv | 32 +++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder:
// access sizes, FSM states and the latched request bundle.
package dmem_responder_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic                  uns;
    logic                  err;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_sram.sv
// Single-port word SRAM with byte write enables and registered read;
// the read register holds its value while the port is disabled.
module dmem_sram
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic [3:0]            i_be,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
      rdata_q <= mem_q[i_addr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store target for the core's data port: one request in flight,
// optional wait states, byte-lane SRAM access, extended load result.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err
);

  localparam int AW = DEPTH_LOG2 + 2;
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            req_err;
  logic            align_err;
  logic            sram_en;
  logic [3:0]      sram_be;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] ext;

  always_comb begin
    align_err = 1'b1;
    unique case (1'b1)
      i_req_size == SIZE_B: align_err = 1'b0;
      i_req_size == SIZE_H: align_err = i_req_addr[0];
      i_req_size == SIZE_W: align_err = |i_req_addr[1:0];
      default:              align_err = 1'b1;
    endcase
    req_err = align_err
            | (|i_req_addr[ADDR_WIDTH-1:AW]);
  end

  assign o_req_ready = (state_q == ST_IDLE) && !i_rst;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid && o_req_ready) begin
          req_d = '{we:    i_req_we,
                    size:  i_req_size,
                    uns:   i_req_unsigned,
                    err:   req_err,
                    wdata: i_req_wdata};
          addr_d  = i_req_addr[AW-1:0];
          cnt_d   = WS_LOAD;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
    req_q  <= req_d;
    addr_q <= addr_d;
    cnt_q  <= cnt_d;
  end

  // Gating with i_rst keeps a reset edge from committing a store.
  assign sram_en = (state_q == ST_ACCESS) && !req_q.err && !i_rst;

  always_comb begin
    sram_be    = 4'b1111;
    sram_wdata = req_q.wdata;
    unique case (1'b1)
      req_q.size == SIZE_B: begin
        sram_be    = 4'b0001 << addr_q[1:0];
        sram_wdata = {4{req_q.wdata[7:0]}};
      end
      req_q.size == SIZE_H: begin
        sram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        sram_wdata = {2{req_q.wdata[15:0]}};
      end
      default: sram_be = 4'b1111;
    endcase
    if (!req_q.we) sram_be = 4'b0000;
  end

  dmem_sram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .i_clk  (i_clk),
    .i_en   (sram_en),
    .i_be   (sram_be),
    .i_addr (addr_q[AW-1:2]),
    .i_wdata(sram_wdata),
    .o_rdata(sram_rdata)
  );

  always_comb begin
    lane = sram_rdata >> {addr_q[1:0], 3'b000};
    ext  = lane;
    unique case (1'b1)
      req_q.size == SIZE_B:
        ext = {{24{!req_q.uns & lane[7]}}, lane[7:0]};
      req_q.size == SIZE_H:
        ext = {{16{!req_q.uns & lane[15]}}, lane[15:0]};
      default: ext = lane;
    endcase
  end

  assign o_rsp_valid = (state_q == ST_RESP);
  assign o_rsp_err   = o_rsp_valid & req_q.err;
  assign o_rsp_rdata =
    (o_rsp_valid && !req_q.err && !req_q.we) ? ext : '0;

endmodule
